keypad_emulator: RTL and testbench

Synthesizable 4x4 matrix-keypad emulator: the responder end of the keypad scan interface, answering the column scan driven by `Driver_teclado` on `fila`. A test sequencer or a UART/control block requests a key press; the block holds that key closed for a programmed number of complete column scans, releases it for a programmed number of scans, then reports completion. It replaces the physical keypad in hardware-in-the-loop and self-test builds of the top level.

---
 rtl/keypad_emulator.sv | 176 +++++++++++++++++
 tb/tb_keypad_emulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder end of a 4x4 matrix-keypad column scan.
// A requested key is held closed for HOLD_SCANS falling edges of its column,
// released for RELEASE_SCANS more edges, then completion is pulsed on done.
// A missing column edge for TIMEOUT_CYC clocks aborts the press and sets error.
module keypad_emulator #(
  parameter int unsigned HOLD_SCANS    = 4,
  parameter int unsigned RELEASE_SCANS = 2,
  parameter int unsigned TIMEOUT_CYC   = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       press,
  input  logic [3:0] col,
  output logic [3:0] fila,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // Timeout counter is wide enough to hold TIMEOUT_CYC itself.
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0]    HOLD_LAST = 4'(HOLD_SCANS);
  localparam logic [3:0]    REL_LAST  = 4'(RELEASE_SCANS);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StDrain,
    StRel,
    StDone
  } state_e;

  state_e        r_state;
  logic [3:0]    r_key;
  logic          r_closed;
  logic [3:0]    r_col_q;
  logic [3:0]    r_scan_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic          w_col_bit;
  logic          w_fe;
  logic [3:0]    w_scan_inc;
  logic [TW-1:0] w_to_inc;
  logic          w_timeout;
  logic [3:0]    w_fila;

  // Column of the latched key and its falling edge against last cycle's sample.
  assign w_col_bit  = col[r_key[1:0]];
  assign w_fe       = r_col_q[r_key[1:0]] & ~w_col_bit;
  assign w_scan_inc = r_scan_cnt + 4'd1;
  assign w_to_inc   = r_to_cnt + TO_ONE;
  // Abort on the edge where the counter would reach the limit.
  assign w_timeout  = (w_to_inc == TO_LIMIT);

  // Row drive behaves like a real switch: combinational from the live column.
  always_comb begin
    w_fila = 4'b1111;
    if (r_closed && !w_col_bit) begin
      w_fila[r_key[3:2]] = 1'b0;
    end
  end

  assign fila  = w_fila;
  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;

  // Press sequencer: hold, drain to the end of the sample window, release, report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_key      <= 4'd0;
      r_closed   <= 1'b0;
      r_col_q    <= 4'b1111;
      r_scan_cnt <= 4'd0;
      r_to_cnt   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_col_q <= col;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (press) begin
            r_key      <= key;
            r_scan_cnt <= 4'd0;
            r_to_cnt   <= '0;
            r_error    <= 1'b0;
            r_closed   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StHold;
          end
        end

        StHold: begin
          // An edge in the same cycle as the timeout wins.
          if (w_fe) begin
            r_scan_cnt <= w_scan_inc;
            r_to_cnt   <= '0;
            if (w_scan_inc == HOLD_LAST) begin
              r_state <= StDrain;
            end
          end else if (w_timeout) begin
            r_to_cnt <= w_to_inc;
            r_closed <= 1'b0;
            r_error  <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= StDone;
          end else begin
            r_to_cnt <= w_to_inc;
          end
        end

        StDrain: begin
          // Open the switch only once the column leaves its low window.
          if (w_col_bit) begin
            r_closed   <= 1'b0;
            r_scan_cnt <= 4'd0;
            r_to_cnt   <= '0;
            r_state    <= StRel;
          end else if (w_timeout) begin
            r_to_cnt <= w_to_inc;
            r_closed <= 1'b0;
            r_error  <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= StDone;
          end else begin
            r_to_cnt <= w_to_inc;
          end
        end

        StRel: begin
          if (w_fe) begin
            r_scan_cnt <= w_scan_inc;
            r_to_cnt   <= '0;
            if (w_scan_inc == REL_LAST) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StDone;
            end
          end else if (w_timeout) begin
            r_to_cnt <= w_to_inc;
            r_closed <= 1'b0;
            r_error  <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= StDone;
          end else begin
            r_to_cnt <= w_to_inc;
          end
        end

        StDone: begin
          r_state <= StIdle;
        end

        default: begin
          r_closed <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: 16-clock column scan (4 clocks per column),
// HOLD_SCANS=4, RELEASE_SCANS=2, TIMEOUT_CYC=1024. Cycle t=0 is the press cycle;
// the press is accepted on the edge that ends it. Inputs driven #1 after posedge,
// outputs sampled at the following negedge.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key;
  logic       press;
  logic [3:0] col;
  logic [3:0] fila;
  logic       busy;
  logic       done;
  logic       error;

  int tests_run    = 0;
  int tests_failed = 0;

  keypad_emulator #(
    .HOLD_SCANS   (4),
    .RELEASE_SCANS(2),
    .TIMEOUT_CYC  (1024)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .key  (key),
    .press(press),
    .col  (col),
    .fila (fila),
    .busy (busy),
    .done (done),
    .error(error)
  );

  always #5 clk = ~clk;

  // Bench scan pattern: 1110, 1101, 1011, 0111, four clocks each.
  function automatic logic [3:0] scan_col(input int t);
    logic [3:0] v;
    v = 4'b1111;
    v[(t / 4) % 4] = 1'b0;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    press = 1'b0;
    key   = 4'd0;
    col   = 4'b1111;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (fila !== 4'b1111) begin
      tests_failed++;
      $display("FAIL reset_fila got %b want 1111", fila);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done got %b want 0", done);
    end
    tests_run++;
    if (error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_error got %b want 0", error);
    end
    repeat (3) @(posedge clk);
    #5 reset = 1'b1;
  endtask

  // One full press under the scan. rel_t: last cycle the key is still closed,
  // done_t: the single cycle done is high. inject_t: cycle of an extra press of
  // key 0 (ignored). zero_t: first of four cycles where col is forced to 0000.
  task automatic test_scan(input string name, input logic [3:0] k, input int rel_t,
                           input int done_t, input int inject_t, input int zero_t);
    logic [3:0] exp_fila;
    int c;
    int r;
    c = int'(k[1:0]);
    r = int'(k[3:2]);
    for (int t = 0; t <= done_t + 4; t++) begin
      @(posedge clk);
      #1;
      col   = (zero_t >= 0 && t >= zero_t && t < zero_t + 4) ? 4'b0000 : scan_col(t);
      press = (t == 0) || (t == inject_t);
      key   = (t == inject_t) ? 4'd0 : k;
      #4;
      exp_fila = 4'b1111;
      if (t >= 1 && t <= rel_t && col[c] == 1'b0) exp_fila[r] = 1'b0;
      tests_run++;
      if (fila !== exp_fila) begin
        tests_failed++;
        $display("FAIL %s_fila t=%0d got %b want %b", name, t, fila, exp_fila);
      end
      tests_run++;
      if (done !== (t == done_t)) begin
        tests_failed++;
        $display("FAIL %s_done t=%0d got %b want %b", name, t, done, (t == done_t));
      end
      tests_run++;
      if (busy !== (t >= 1 && t < done_t)) begin
        tests_failed++;
        $display("FAIL %s_busy t=%0d got %b want %b", name, t, busy,
                 (t >= 1 && t < done_t));
      end
      if (t == 1 || t == done_t) begin
        tests_run++;
        if (error !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s_error t=%0d got %b want 0", name, t, error);
        end
      end
    end
    press = 1'b0;
  endtask

  // Column never toggles: abort registered on the edge 1024 clocks after acceptance.
  task automatic test_timeout();
    for (int t = 0; t <= 1030; t++) begin
      @(posedge clk);
      #1;
      col   = 4'b1111;
      press = (t == 0);
      key   = 4'd6;
      #4;
      tests_run++;
      if (fila !== 4'b1111) begin
        tests_failed++;
        $display("FAIL timeout_fila t=%0d got %b want 1111", t, fila);
      end
      tests_run++;
      if (done !== (t == 1025)) begin
        tests_failed++;
        $display("FAIL timeout_done t=%0d got %b want %b", t, done, (t == 1025));
      end
      tests_run++;
      if (busy !== (t >= 1 && t < 1025)) begin
        tests_failed++;
        $display("FAIL timeout_busy t=%0d got %b want %b", t, busy, (t >= 1 && t < 1025));
      end
      if (t == 1025 || t == 1030) begin
        tests_run++;
        if (error !== 1'b1) begin
          tests_failed++;
          $display("FAIL timeout_error t=%0d got %b want 1", t, error);
        end
      end
    end
    press = 1'b0;
  endtask

  // Reset while key 6 is pulling row 1 low.
  task automatic test_reset_mid();
    for (int t = 0; t <= 9; t++) begin
      @(posedge clk);
      #1;
      col   = scan_col(t);
      press = (t == 0);
      key   = 4'd6;
      #4;
    end
    press = 1'b0;
    tests_run++;
    if (fila !== 4'b1101) begin
      tests_failed++;
      $display("FAIL reset_mid_pre_fila got %b want 1101", fila);
    end
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if (fila !== 4'b1111) begin
      tests_failed++;
      $display("FAIL reset_mid_fila got %b want 1111", fila);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_busy got %b want 0", busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #5;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || fila !== 4'b1111) begin
        tests_failed++;
        $display("FAIL reset_mid_hold i=%0d got done=%b busy=%b fila=%b want 0 0 1111",
                 i, done, busy, fila);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan("key6", 4'd6, 60, 89, -1, -1);
    test_scan("key15", 4'd15, 64, 93, -1, -1);
    test_timeout();
    test_scan("second_press", 4'd6, 60, 89, 20, -1);
    test_reset_mid();
    test_scan("after_reset", 4'd6, 60, 89, -1, -1);
    test_scan("col_zero_key9", 4'd9, 56, 85, -1, 8);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
